// File: rtl/brom_port_arbiter.sv
// rtl/brom_port_arbiter.sv - boot ROM port arbiter: fetch (16-bit) vs data (byte) on one single-port ROM
// Optional BROM_ARB_PERF_EN adds conflict / forced-grant counters.
module brom_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_if_req,
  input  logic [8:0]  i_if_addr,
  output logic        o_if_gnt,
  output logic        o_if_valid,
  output logic [15:0] o_if_insn,
  input  logic        i_d_req,
  input  logic [9:0]  i_d_addr,
  output logic        o_d_gnt,
  output logic        o_d_valid,
  output logic [7:0]  o_d_data,
  output logic        o_rom_en,
  output logic [8:0]  o_rom_addr,
  input  logic [7:0]  i_rom_dout_h,
  input  logic [7:0]  i_rom_dout_l
`ifdef BROM_ARB_PERF_EN
  ,
  output logic [15:0] o_conflict_cnt,
  output logic [15:0] o_force_cnt
`endif
);

  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_t;

  owner_t           r_owner;
  logic             r_sel;
  logic [CNT_W-1:0] r_starve_cnt;
  logic [15:0]      r_if_hold;
  logic [7:0]       r_d_hold;
  logic [8:0]       r_last_addr;

  logic        w_force;
  logic        w_if_gnt;
  logic        w_d_gnt;
  logic        w_if_resp;
  logic        w_d_resp;
  logic [15:0] w_rom_word;
  logic [7:0]  w_d_byte;

  assign w_force  = (r_starve_cnt >= CNT_W'(STARVE_LIMIT));
  assign w_d_gnt  = !i_rst && i_d_req && (!i_if_req || w_force);
  assign w_if_gnt = !i_rst && i_if_req && !w_d_gnt;

  // Reset masks a response owed to a grant made just before reset.
  assign w_if_resp  = (r_owner == OWN_IF) && !i_rst;
  assign w_d_resp   = (r_owner == OWN_D) && !i_rst;
  assign w_rom_word = {i_rom_dout_h, i_rom_dout_l};
  assign w_d_byte   = r_sel ? i_rom_dout_l : i_rom_dout_h;

  assign o_if_gnt   = w_if_gnt;
  assign o_d_gnt    = w_d_gnt;
  assign o_rom_en   = w_if_gnt || w_d_gnt;
  assign o_rom_addr = w_if_gnt ? i_if_addr : (w_d_gnt ? i_d_addr[9:1] : r_last_addr);
  assign o_if_valid = w_if_resp;
  assign o_d_valid  = w_d_resp;
  assign o_if_insn  = i_rst ? 16'hF000 : (w_if_resp ? w_rom_word : r_if_hold);
  assign o_d_data   = i_rst ? 8'h00 : (w_d_resp ? w_d_byte : r_d_hold);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_owner      <= OWN_NONE;
      r_sel        <= 1'b0;
      r_starve_cnt <= '0;
      r_if_hold    <= 16'hF000;
      r_d_hold     <= 8'h00;
      r_last_addr  <= 9'h000;
    end else begin
      if (i_d_req && !w_d_gnt) begin
        if (r_starve_cnt != {CNT_W{1'b1}})
          r_starve_cnt <= r_starve_cnt + 1'b1;
      end else begin
        r_starve_cnt <= '0;
      end

      if (w_if_gnt) begin
        r_owner     <= OWN_IF;
        r_last_addr <= i_if_addr;
      end else if (w_d_gnt) begin
        r_owner     <= OWN_D;
        r_sel       <= i_d_addr[0];
        r_last_addr <= i_d_addr[9:1];
      end else begin
        r_owner <= OWN_NONE;
      end

      if (w_if_resp)
        r_if_hold <= w_rom_word;
      if (w_d_resp)
        r_d_hold <= w_d_byte;
    end
  end

`ifdef BROM_ARB_PERF_EN
  logic [15:0] r_conflict_cnt;
  logic [15:0] r_force_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_conflict_cnt <= 16'h0000;
      r_force_cnt    <= 16'h0000;
    end else begin
      if (i_if_req && i_d_req && r_conflict_cnt != 16'hFFFF)
        r_conflict_cnt <= r_conflict_cnt + 16'h0001;
      // Only conflicts resolved by the starvation limit count as forced.
      if (i_if_req && w_d_gnt && r_force_cnt != 16'hFFFF)
        r_force_cnt <= r_force_cnt + 16'h0001;
    end
  end

  assign o_conflict_cnt = r_conflict_cnt;
  assign o_force_cnt    = r_force_cnt;
`endif

endmodule

// File: tb/tb_brom_port_arbiter.sv
// tb/tb_brom_port_arbiter.sv - scoreboard bench for brom_port_arbiter with a registered ROM model
module tb_brom_port_arbiter;
  localparam int LIMIT = 4;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_if_req;
  logic [8:0]  i_if_addr;
  logic        o_if_gnt;
  logic        o_if_valid;
  logic [15:0] o_if_insn;
  logic        i_d_req;
  logic [9:0]  i_d_addr;
  logic        o_d_gnt;
  logic        o_d_valid;
  logic [7:0]  o_d_data;
  logic        o_rom_en;
  logic [8:0]  o_rom_addr;
  logic [7:0]  i_rom_dout_h;
  logic [7:0]  i_rom_dout_l;
`ifdef BROM_ARB_PERF_EN
  logic [15:0] o_conflict_cnt;
  logic [15:0] o_force_cnt;
`endif

  always #5 i_clk = ~i_clk;

  brom_port_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_gnt(o_if_gnt),
    .o_if_valid(o_if_valid), .o_if_insn(o_if_insn),
    .i_d_req(i_d_req), .i_d_addr(i_d_addr), .o_d_gnt(o_d_gnt),
    .o_d_valid(o_d_valid), .o_d_data(o_d_data),
    .o_rom_en(o_rom_en), .o_rom_addr(o_rom_addr),
    .i_rom_dout_h(i_rom_dout_h), .i_rom_dout_l(i_rom_dout_l)
`ifdef BROM_ARB_PERF_EN
    , .o_conflict_cnt(o_conflict_cnt), .o_force_cnt(o_force_cnt)
`endif
  );

  logic [15:0] mem [0:511];

  always @(posedge i_clk) begin
    if (o_rom_en) begin
      i_rom_dout_h <= mem[o_rom_addr][15:8];
      i_rom_dout_l <= mem[o_rom_addr][7:0];
    end
  end

  typedef struct {
    int          kind;
    logic [15:0] val;
  } resp_t;

  resp_t       sb[$];
  int          checks = 0;
  int          errors = 0;
  int          m_cnt;
  logic [15:0] m_if_hold;
  logic [7:0]  m_d_hold;
  logic [8:0]  m_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt     = 0;
    m_if_hold = 16'hF000;
    m_d_hold  = 8'h00;
    m_addr    = 9'h000;
    sb.delete();
  endtask

  task automatic do_reset(input int n);
    i_rst = 1'b1; i_if_req = 1'b0; i_d_req = 1'b0;
    repeat (n) @(posedge i_clk);
    @(negedge i_clk);
    check("rst_rom_en", o_rom_en, 0);
    check("rst_gnt", {o_if_gnt, o_d_gnt}, 0);
    check("rst_valid", {o_if_valid, o_d_valid}, 0);
    check("rst_insn", o_if_insn, 16'hF000);
    check("rst_data", o_d_data, 8'h00);
`ifdef BROM_ARB_PERF_EN
    check("rst_perf", {o_conflict_cnt, o_force_cnt}, 0);
`endif
    i_rst = 1'b0;
    model_reset();
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic drive_cycle(input logic ir, input logic [8:0] ia, input logic dr, input logic [9:0] da);
    logic  ed, ei;
    resp_t r;
    i_if_req = ir; i_if_addr = ia; i_d_req = dr; i_d_addr = da;
    #1;
    ed = dr && (!ir || (m_cnt >= LIMIT));
    ei = ir && !ed;
    check("if_gnt", o_if_gnt, ei);
    check("d_gnt", o_d_gnt, ed);
    check("rom_en", o_rom_en, ei | ed);
    if (ei) m_addr = ia;
    else if (ed) m_addr = da[9:1];
    check("rom_addr", o_rom_addr, m_addr);
    r.kind = ei ? 1 : (ed ? 2 : 0);
    r.val  = ei ? mem[ia] : (ed ? (da[0] ? {8'h00, mem[da[9:1]][7:0]} : {8'h00, mem[da[9:1]][15:8]}) : 16'h0000);
    sb.push_back(r);
    m_cnt = (dr && !ed) ? ((m_cnt < 15) ? m_cnt + 1 : m_cnt) : 0;
    @(posedge i_clk);
    @(negedge i_clk);
    r = sb.pop_front();
    if (r.kind == 1) m_if_hold = r.val;
    if (r.kind == 2) m_d_hold = r.val[7:0];
    check("if_valid", o_if_valid, r.kind == 1);
    check("d_valid", o_d_valid, r.kind == 2);
    check("if_insn", o_if_insn, m_if_hold);
    check("d_data", o_d_data, m_d_hold);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 16'(i * 16'h0101) ^ 16'h5AC3;
    mem[5] = 16'h1234;
    i_rst = 1'b1; i_if_req = 1'b0; i_if_addr = '0; i_d_req = 1'b0; i_d_addr = '0;
    model_reset();
    @(negedge i_clk);
    do_reset(2);

    repeat (2) drive_cycle(1'b0, 9'h000, 1'b0, 10'h000);

    drive_cycle(1'b1, 9'h005, 1'b0, 10'h000);
    check("fetch_1234", o_if_insn, 16'h1234);
    drive_cycle(1'b0, 9'h1FF, 1'b0, 10'h000);
    check("fetch_hold", o_if_insn, 16'h1234);

    drive_cycle(1'b0, 9'h000, 1'b1, 10'h00A);
    check("byte_even", o_d_data, 8'h12);
    drive_cycle(1'b0, 9'h000, 1'b1, 10'h00B);
    check("byte_odd", o_d_data, 8'h34);
    drive_cycle(1'b0, 9'h000, 1'b0, 10'h000);

    do_reset(1);
    for (int i = 0; i < 10; i++)
      drive_cycle(1'b1, 9'(i + 1), 1'b1, 10'(2 * i + 40));
`ifdef BROM_ARB_PERF_EN
    check("conflict_cnt", o_conflict_cnt, 16'd10);
    check("force_cnt", o_force_cnt, 16'd2);
`endif
    drive_cycle(1'b0, 9'h000, 1'b0, 10'h000);

    i_if_req = 1'b1; i_if_addr = 9'h005; i_d_req = 1'b0;
    #1 check("mr_gnt", o_if_gnt, 1);
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b1; i_d_req = 1'b1;
    #1;
    check("mr_valid", o_if_valid, 0);
    check("mr_insn", o_if_insn, 16'hF000);
    check("mr_gnt_rst", {o_if_gnt, o_d_gnt, o_rom_en}, 0);
    @(posedge i_clk);
    @(negedge i_clk);
    check("mr_insn2", o_if_insn, 16'hF000);
    i_rst = 1'b0; i_if_req = 1'b0; i_d_req = 1'b0;
    model_reset();
    @(posedge i_clk);
    @(negedge i_clk);
    check("mr_no_stale", {o_if_valid, o_d_valid}, 0);
    check("mr_insn3", o_if_insn, 16'hF000);

    for (int i = 0; i < 60; i++)
      drive_cycle(1'($urandom_range(0, 1)), 9'($urandom_range(0, 511)),
                  1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)));

`ifdef BROM_ARB_PERF_EN
    do_reset(1);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/brom_port_arbiter.md
Name: brom_port_arbiter

Overview:
- Shares the single-port 1 KB big-endian boot ROM between two requesters: instruction fetch (16-bit words) and data load (bytes).
- Grants one requester per cycle and drives the ROM enable and word address.
- Steers the ROM's registered hi/lo bytes back to the owning requester one cycle later.
- Holds the last fetched instruction stable, so an interleaved data read never corrupts the fetch output.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles a pending data request may be denied before it is force-granted; 0 = data has strict priority.
- CNT_W, 4: width of the starvation counter; STARVE_LIMIT must be < 2^CNT_W.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_if_req  in  1  fetch request
- i_if_addr  in  9  fetch word address [9:1]
- o_if_gnt  out  1  fetch granted this cycle (combinational)
- o_if_valid  out  1  fetch data valid (cycle after grant)
- o_if_insn  out  16  instruction {hi,lo}
- i_d_req  in  1  data byte request
- i_d_addr  in  10  data byte address [9:0]
- o_d_gnt  out  1  data granted this cycle (combinational)
- o_d_valid  out  1  data byte valid (cycle after grant)
- o_d_data  out  8  data byte
- o_rom_en  out  1  ROM read enable
- o_rom_addr  out  9  ROM word address
- i_rom_dout_h  in  8  ROM high (even) byte
- i_rom_dout_l  in  8  ROM low (odd) byte

Behaviour:
- Reset i_rst, synchronous, active-high; clock i_clk.
- Reset values:
  - o_if_valid=0, o_d_valid=0.
  - o_if_insn=16'hF000 (NOP), o_d_data=8'h00.
  - Starvation counter=0, pending owner=NONE.
  - While i_rst is high: o_rom_en=0, both gnt=0.
- Grant (combinational, at most one per cycle):
  - If only one requester is active, it is granted.
  - If both are active: fetch wins unless starve_cnt >= STARVE_LIMIT, in which case data wins.
- Starvation counter:
  - Increments (saturating) each cycle i_d_req=1 and o_d_gnt=0.
  - Clears on o_d_gnt=1 or when i_d_req=0.
- ROM drive:
  - o_rom_en = o_if_gnt | o_d_gnt.
  - o_rom_addr = i_if_addr when fetch is granted, else i_d_addr[9:1].
  - When idle, o_rom_addr holds its last value; the ROM ignores it since en=0.
- Pending owner register (NONE/IF/D) plus registered byte-select bit (i_d_addr[0]), loaded on each grant. Next state is IF, D or NONE per that cycle's grant.
- Response (latency exactly 1 cycle after grant):
  - Owner IF: o_if_valid=1 and o_if_insn={i_rom_dout_h,i_rom_dout_l}. The value is also captured into the hold register.
  - Owner D: o_d_valid=1 and o_d_data = sel ? i_rom_dout_l : i_rom_dout_h (even byte = high, big-endian). The value is also captured into the data hold register.
  - When no valid is pending, o_if_insn and o_d_data present their hold registers (last delivered value).
- Back-to-back grants to either side are legal every cycle; throughput is 1 read/cycle total.
- Requester may change address or drop its request freely; only the grant cycle samples it. No request queuing: a denied request must be held by the requester.
- Reset mid-operation: pending owner is cleared, no valid is issued in the cycle after reset, and hold registers return to reset values.
- Simultaneous events:
  - If starve_cnt reaches STARVE_LIMIT in the same cycle fetch drops its request, data is granted normally and the counter clears.
  - STARVE_LIMIT=0: data always wins a conflict.

Optional Feature:
- BROM_ARB_PERF_EN defined:
  - Adds outputs o_conflict_cnt (16) and o_force_cnt (16).
  - o_conflict_cnt counts cycles with both requests active.
  - o_force_cnt counts grants to data caused by the starvation limit.
  - Both saturate at 16'hFFFF and clear on i_rst.
- Not defined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then idle:
  - i_rst=1 for 2 cycles -> o_rom_en=0, o_if_insn=16'hF000, o_d_data=8'h00, both valids 0.
  - Release and leave idle -> outputs unchanged.
- Fetch only:
  - ROM word 0x005 = hi 8'h12, lo 8'h34; i_if_req=1, i_if_addr=9'h005 -> o_if_gnt=1, o_rom_en=1, o_rom_addr=9'h005.
  - Next cycle -> o_if_valid=1, o_if_insn=16'h1234; value holds after req drops.
- Data byte steering, same word:
  - i_d_addr=10'h00A -> o_d_data=8'h12.
  - i_d_addr=10'h00B -> o_d_data=8'h34.
  - Valid exactly 1 cycle after each gnt.
- Conflict with STARVE_LIMIT=4:
  - Both requests held high continuously -> fetch granted cycles 0–3, data granted cycle 4, counter clears, fetch granted cycle 5.
  - o_if_insn unchanged during the data response cycle.
- Reset mid-read:
  - Grant fetch, assert i_rst in the next cycle -> o_if_valid stays 0, o_if_insn=16'hF000.
  - No stale valid after reset release.
- With BROM_ARB_PERF_EN:
  - Run the conflict scenario for 10 cycles -> o_conflict_cnt=10, o_force_cnt=2.
  - Assert i_rst -> both counters 0.
